// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus controller.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    DATA  = 2'b10,
    TURN  = 2'b11
  } state_t;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam int TIMEOUT_CYC_DEFAULT = 16;

  // The unused encoding 11 falls back to a full-word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    case (size)
      SIZE_HALF: return SIZE_HALF;
      SIZE_BYTE: return SIZE_BYTE;
      default:   return SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/bus_timer.sv
// Per-access wait-cycle counter; expired flags the final permitted cycle without ack.
module bus_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// Arbitrates instruction fetches and load/stores onto one external memory bus.
// Define BUS_TIMEOUT_EN to abort accesses that wait more than TIMEOUT_CYC cycles for ack.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        bus_req,
  output logic        bus_write,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_wdata_oe,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack_n,
  output logic        stall,
  output logic        bus_err
);

  state_t state;
  logic   ack_now;
  logic   expired;

  assign ack_now = ~bus_ack_n;

`ifdef BUS_TIMEOUT_EN
  logic tmr_clear;
  logic tmr_en;

  assign tmr_clear = (state == IDLE);
  assign tmr_en    = ((state == FETCH) || (state == DATA)) && bus_ack_n;

  bus_timer #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(expired)
  );
`else
  logic timeout_unused;

  assign expired        = 1'b0;
  assign timeout_unused = (TIMEOUT_CYC != 0);
`endif

  assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);

  // Bus fields are captured at grant and held untouched until the access ends.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      bus_req      <= 1'b0;
      bus_write    <= 1'b0;
      bus_size     <= SIZE_WORD;
      bus_addr     <= '0;
      bus_wdata    <= '0;
      bus_wdata_oe <= 1'b0;
      if_ready     <= 1'b0;
      if_rdata     <= '0;
      d_ready      <= 1'b0;
      d_rdata      <= '0;
      bus_err      <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req) begin
            state        <= DATA;
            bus_req      <= 1'b1;
            bus_write    <= d_we;
            bus_size     <= norm_size(d_size);
            bus_addr     <= d_addr;
            bus_wdata    <= d_we ? d_wdata : '0;
            bus_wdata_oe <= d_we;
          end else if (if_req) begin
            state        <= FETCH;
            bus_req      <= 1'b1;
            bus_write    <= 1'b0;
            bus_size     <= SIZE_WORD;
            bus_addr     <= if_addr;
            bus_wdata    <= '0;
            bus_wdata_oe <= 1'b0;
          end
        end
        FETCH, DATA: begin
          // An ack on the last permitted cycle still completes normally.
          if (ack_now || expired) begin
            state        <= TURN;
            bus_req      <= 1'b0;
            bus_wdata_oe <= 1'b0;
            bus_err      <= ~ack_now;
            if (state == FETCH) begin
              if_ready <= 1'b1;
              if_rdata <= ack_now ? bus_rdata : '0;
            end else begin
              d_ready <= 1'b1;
              d_rdata <= (ack_now && !bus_write) ? bus_rdata : '0;
            end
          end
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized self-checking bench for mem_bus_ctrl against a transaction-level model.
module tb_mem_bus_ctrl;

  localparam int TCYC = 4;

  typedef enum int {K_FETCH, K_LOAD, K_STORE} kind_t;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        bus_req;
  logic        bus_write;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wdata_oe;
  logic [31:0] bus_rdata;
  logic        bus_ack_n;
  logic        stall;
  logic        bus_err;

  int          assertions = 0;
  int          failures   = 0;
  logic [31:0] last_if    = '0;
  logic [31:0] last_d     = '0;
  int          slave_waits = 0;
  logic [31:0] slave_rv    = '0;
  int          slave_bc    = 0;

  mem_bus_ctrl #(
    .TIMEOUT_CYC(TCYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ready    (if_ready),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_size      (d_size),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ready     (d_ready),
    .bus_req     (bus_req),
    .bus_write   (bus_write),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wdata_oe(bus_wdata_oe),
    .bus_rdata   (bus_rdata),
    .bus_ack_n   (bus_ack_n),
    .stall       (stall),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory slave: acknowledges after slave_waits wait states, garbage data otherwise.
  always @(negedge clk) begin
    if (bus_req) begin
      slave_bc = slave_bc + 1;
      if (slave_bc == slave_waits + 1) begin
        bus_ack_n = 1'b0;
        bus_rdata = slave_rv;
      end else begin
        bus_ack_n = 1'b1;
        bus_rdata = $urandom;
      end
    end else begin
      slave_bc  = 0;
      bus_ack_n = 1'b1;
      bus_rdata = $urandom;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input kind_t kind, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
    if (kind == K_FETCH) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      d_req   = 1'b1;
      d_we    = (kind == K_STORE);
      d_size  = size;
      d_addr  = addr;
      d_wdata = wdata;
    end
  endtask

  // One complete access; expectations come from the access-level rules.
  task automatic runAccess(input kind_t kind, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rv, input int waits);
    logic [1:0]  exp_size;
    logic [31:0] exp_r;
    bit          store;
    bit          abort;
    bit          done;
    int          exp_lat;
    store    = (kind == K_STORE);
    exp_size = (kind == K_FETCH || size == 2'b11) ? 2'b00 : size;
    abort    = 1'b0;
    exp_lat  = waits + 2;
`ifdef BUS_TIMEOUT_EN
    if (waits >= TCYC) begin
      abort   = 1'b1;
      exp_lat = TCYC + 1;
    end
`endif
    slave_waits = waits;
    slave_rv    = rv;
    applyStimulus(kind, size, addr, wdata);
    done = 1'b0;
    for (int c = 1; c <= 200 && !done; c++) begin
      @(negedge clk);
      if (if_ready || d_ready) begin
        done = 1'b1;
        checkOutput("latency", c, exp_lat);
        checkOutput("ready_sel", {if_ready, d_ready}, (kind == K_FETCH) ? 2'b10 : 2'b01);
        checkOutput("bus_req_drop", bus_req, 1'b0);
        checkOutput("oe_drop", bus_wdata_oe, 1'b0);
        checkOutput("bus_err", bus_err, abort);
        exp_r = (store || abort) ? 32'h0 : rv;
        if (kind == K_FETCH) last_if = exp_r;
        else last_d = exp_r;
        checkOutput("if_rdata", if_rdata, last_if);
        checkOutput("d_rdata", d_rdata, last_d);
        checkOutput("stall_ready", stall, 1'b0);
        if_req = 1'b0;
        d_req  = 1'b0;
      end else begin
        checkOutput("bus_req", bus_req, 1'b1);
        checkOutput("bus_addr", bus_addr, addr);
        checkOutput("bus_size", bus_size, exp_size);
        checkOutput("bus_write", bus_write, store);
        checkOutput("bus_wdata_oe", bus_wdata_oe, store);
        if (store) checkOutput("bus_wdata", bus_wdata, wdata);
        checkOutput("stall_busy", stall, 1'b1);
        checkOutput("bus_err_busy", bus_err, 1'b0);
        checkOutput("rdata_hold", (kind == K_FETCH) ? if_rdata : d_rdata,
                    (kind == K_FETCH) ? last_if : last_d);
      end
    end
    checkOutput("ready_seen", done, 1'b1);
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
    checkOutput("ready_width", {if_ready, d_ready}, 2'b00);
    checkOutput("turn_bus_idle", bus_req, 1'b0);
    checkOutput("stall_idle", stall, 1'b0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    kind_t       kind;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rv;
    rst       = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_size    = 2'b00;
    d_addr    = '0;
    d_wdata   = '0;
    bus_rdata = '0;
    bus_ack_n = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("rst_bus_req", bus_req, 1'b0);
    checkOutput("rst_oe", bus_wdata_oe, 1'b0);
    checkOutput("rst_addr", bus_addr, 32'h0);
    checkOutput("rst_ready", {if_ready, d_ready}, 2'b00);
    checkOutput("rst_rdata", {if_rdata, d_rdata}, 64'h0);
    checkOutput("rst_err", bus_err, 1'b0);
    checkOutput("rst_stall", stall, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] directed fetch, store, size-11 load");
    runAccess(K_FETCH, 2'b00, 32'h0001_0000, 32'h0, 32'hCAFE_0123, 0);
    runAccess(K_STORE, 2'b00, 32'h0000_4000, 32'hDEAD_BEEF, 32'h1234_5678, 3);
    runAccess(K_LOAD, 2'b11, 32'h0000_4004, 32'h0, 32'h8765_4321, 1);

    $display("[TB] simultaneous fetch and byte load");
    slave_waits = 0;
    slave_rv    = 32'hA5A5_0001;
    if_req  = 1'b1;
    if_addr = 32'h0001_0000;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_size  = 2'b10;
    d_addr  = 32'h0000_2000;
    @(negedge clk);
    checkOutput("sim_data_addr", bus_addr, 32'h0000_2000);
    checkOutput("sim_data_size", bus_size, 2'b10);
    checkOutput("sim_data_write", bus_write, 1'b0);
    checkOutput("sim_stall1", stall, 1'b1);
    @(negedge clk);
    checkOutput("sim_d_ready", {if_ready, d_ready}, 2'b01);
    checkOutput("sim_d_rdata", d_rdata, 32'hA5A5_0001);
    checkOutput("sim_stall2", stall, 1'b1);
    last_d   = 32'hA5A5_0001;
    d_req    = 1'b0;
    slave_rv = 32'h5A5A_0002;
    @(negedge clk);
    checkOutput("sim_turn_req", bus_req, 1'b0);
    checkOutput("sim_stall3", stall, 1'b1);
    @(negedge clk);
    checkOutput("sim_fetch_addr", bus_addr, 32'h0001_0000);
    checkOutput("sim_fetch_size", bus_size, 2'b00);
    checkOutput("sim_stall4", stall, 1'b1);
    @(negedge clk);
    checkOutput("sim_if_ready", {if_ready, d_ready}, 2'b10);
    checkOutput("sim_if_rdata", if_rdata, 32'h5A5A_0002);
    checkOutput("sim_d_hold", d_rdata, 32'hA5A5_0001);
    last_if = 32'h5A5A_0002;
    if_req  = 1'b0;
    @(negedge clk);

    $display("[TB] randomized accesses");
    for (int i = 0; i < 40; i++) begin
      kind  = kind_t'($urandom_range(0, 2));
      size  = 2'($urandom);
      addr  = $urandom;
      wdata = $urandom;
      rv    = $urandom;
      runAccess(kind, size, addr, wdata, rv, $urandom_range(0, 5));
    end

`ifdef BUS_TIMEOUT_EN
    $display("[TB] timeout boundary");
    runAccess(K_LOAD, 2'b00, 32'h0000_3000, 32'h0, 32'h1111_2222, TCYC - 1);
    runAccess(K_LOAD, 2'b00, 32'h0000_3004, 32'h0, 32'h3333_4444, 1000);
    runAccess(K_FETCH, 2'b00, 32'h0000_3008, 32'h0, 32'h5555_6666, 1000);
`else
    $display("[TB] long wait without timeout");
    runAccess(K_LOAD, 2'b00, 32'h0000_3000, 32'h0, 32'h1111_2222, 20);
`endif

    $display("[TB] reset during data access");
    runAccess(K_LOAD, 2'b01, 32'h0000_5000, 32'h0, 32'h0BAD_F00D, 0);
    slave_waits = 10;
    applyStimulus(K_STORE, 2'b00, 32'h0000_6000, 32'h1357_9BDF);
    @(negedge clk);
    checkOutput("mid_bus_req", bus_req, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_req", bus_req, 1'b0);
    checkOutput("mid_rst_oe", bus_wdata_oe, 1'b0);
    checkOutput("mid_rst_ready", d_ready, 1'b0);
    checkOutput("mid_rst_rdata", d_rdata, 32'h0);
    rst     = 1'b1;
    d_req   = 1'b0;
    last_if = '0;
    last_d  = '0;
    @(negedge clk);
    checkOutput("post_rst_ready", d_ready, 1'b0);
    checkOutput("post_rst_req", bus_req, 1'b0);
    runAccess(K_FETCH, 2'b00, 32'h0000_7000, 32'h0, 32'h2468_ACE0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, meaning bus cycles allowed per access before abort (used only with BUS_TIMEOUT_EN).
REQ-002 SHALL have clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have if_req  input  1  instruction fetch request, held until if_ready.
REQ-005 SHALL have if_addr  input  32  fetch address.
REQ-006 SHALL have if_rdata  output  32  fetched word, valid when if_ready=1.
REQ-007 SHALL have if_ready  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have d_req  input  1  load/store request, held until d_ready.
REQ-009 SHALL have d_we  input  1  1=store, 0=load.
REQ-010 SHALL have d_size  input  2  00 word, 01 half, 10 byte.
REQ-011 SHALL have d_addr and d_wdata  input  32 each  data address and store data.
REQ-012 SHALL have d_rdata  output  32  load data, valid when d_ready=1.
REQ-013 SHALL have d_ready  output  1  one-cycle data completion pulse.
REQ-014 SHALL have bus_req, bus_write  output  1 each  external MREQ/WRITE.
REQ-015 SHALL have bus_size  output  2; bus_addr, bus_wdata  output  32  external access fields.
REQ-016 SHALL have bus_wdata_oe  output  1  drive enable for bidirectional data bus.
REQ-017 SHALL have bus_rdata  input  32; bus_ack_n  input  1  active-low acknowledge.
REQ-018 SHALL have stall  output  1; bus_err  output  1  timeout-abort pulse.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, DATA, TURN.
REQ-020 IDLE: d_req=1 -> DATA (data wins over simultaneous if_req); else if_req=1 -> FETCH; else stay.
REQ-021 Bus outputs SHALL be registered; bus_req=1 from first cycle in FETCH/DATA, bus_addr/size/write/wdata latched at grant and held constant until completion.
REQ-022 FETCH SHALL drive bus_write=0, bus_size=00, bus_wdata_oe=0.
REQ-023 DATA SHALL drive bus_write=d_we, bus_size=d_size, bus_wdata_oe=d_we.
REQ-024 bus_ack_n sampled 0 in FETCH/DATA SHALL end the access: next cycle bus_req=0, bus_wdata_oe=0, matching ready=1 for exactly one cycle, rdata = registered bus_rdata (0 for stores), state TURN.
REQ-025 TURN SHALL last exactly one cycle, ignore requests, then go to IDLE; minimum request-to-ready latency 3 cycles (grant, ack, ready).
REQ-026 bus_ack_n=0 while in IDLE or TURN SHALL be ignored.
REQ-027 stall SHALL equal (if_req & ~if_ready) | (d_req & ~d_ready), combinational.
REQ-028 if_rdata/d_rdata SHALL hold their last value between ready pulses.
REQ-029 Requests with size 11 SHALL be treated as word.

Reset
REQ-030 rst=0 at a posedge SHALL force IDLE, all outputs 0, rdata registers 0, timeout counter 0.
REQ-031 Reset mid-access SHALL drop bus_req and bus_wdata_oe next cycle with no ready pulse issued.

Configuration
REQ-032 Macro BUS_TIMEOUT_EN defined: counter clears at grant, increments each FETCH/DATA cycle without ack; after TIMEOUT_CYC such cycles, access aborts as in REQ-024 with rdata=0 and bus_err=1 for that same one cycle.
REQ-033 Ack in the same cycle as the counter limit SHALL complete normally (ack wins).
REQ-034 BUS_TIMEOUT_EN undefined: no counter, wait indefinitely, bus_err tied 0.

Structure
REQ-035 Package mem_bus_pkg SHALL hold the state enum, SIZE encodings (WORD=00, HALF=01, BYTE=10), and default TIMEOUT_CYC.
REQ-036 Timeout counter SHALL be sub-module bus_timer (clear, enable, expired), instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-037 Fetch: if_req, if_addr=0x10000, ack_n=0 one cycle after bus_req -> bus_addr=0x10000, size=00, if_ready pulse with if_rdata=bus_rdata, total 3 cycles.
REQ-038 Simultaneous if_req and d_req (load 0x2000, byte) -> data access first (bus_size=10), then TURN, then fetch; stall=1 throughout.
REQ-039 Store d_wdata=0xDEADBEEF, 3 wait states -> bus_wdata_oe=1, bus_write=1, fields stable 4 cycles, d_ready=1, d_rdata=0.
REQ-040 Reset asserted in second cycle of DATA -> bus_req=0 next cycle, no d_ready, IDLE.
REQ-041 BUS_TIMEOUT_EN, TIMEOUT_CYC=4, ack_n held 1 -> abort after 4 cycles: bus_err and d_ready pulse together, d_rdata=0; ack on cycle 4 -> normal completion, bus_err=0.
